// File: rtl/wb_stage_if.sv
// ----------------------------------------------------------------------------
// wb_stage_if
// Result bundle handshake between the MEM stage (master) and the writeback
// stage (slave).
//   mem_valid   master->slave  bundle valid
//   mem_ready   slave->master  writeback can take a bundle
//   mem_kind    master->slave  00 ALU, 01 32-bit load, 10 128-bit load, 11 as 00
//   mem_addr    master->slave  four lane register addresses, lane0 in LSBs
//   mem_en      master->slave  per-lane 32-bit write enables
//   mem_en_128  master->slave  128-bit register write enable
//   mem_data    master->slave  four lane data words, lane0 in LSBs
// ----------------------------------------------------------------------------
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic                  mem_valid;
  logic                  mem_ready;
  logic [1:0]            mem_kind;
  logic [4*ADDR_W-1:0]   mem_addr;
  logic [3:0]            mem_en;
  logic                  mem_en_128;
  logic [4*DATA_W-1:0]   mem_data;

  modport master (
    output mem_valid, mem_kind, mem_addr, mem_en, mem_en_128, mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_kind, mem_addr, mem_en, mem_en_128, mem_data,
    output mem_ready
  );
endinterface

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
// Writeback stage. Takes result bundles from MEM, merges data-memory load
// beats, and drives the register-file write ports (four 32-bit lanes plus a
// 128-bit write built from the same four lanes). A 128-bit load arrives as
// four beats which are collected and committed as a single write.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard any uncommitted bundle, block accept
//   mem (slave)         bundle handshake from MEM
//   dmem_rvalid/rdata   one load beat per valid cycle
//   write_addr1..4      register write addresses (hold between commits)
//   write_en1_32..4_32  single-cycle 32-bit write strobes
//   write_en_128        single-cycle 128-bit write strobe
//   write_data_1..4     lane write data (hold between commits)
//   wb_rd               lane0 address of a waiting load, else 0
//   wb_busy             a load bundle is waiting for data
//   err_timeout         pulse: waiting load dropped after TIMEOUT idle cycles
//   err_spurious        pulse: load beat seen while nothing was waiting
// ----------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  wb_stage_if.slave         mem,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] write_addr1,
  output logic [ADDR_W-1:0] write_addr2,
  output logic [ADDR_W-1:0] write_addr3,
  output logic [ADDR_W-1:0] write_addr4,
  output logic              write_en1_32,
  output logic              write_en2_32,
  output logic              write_en3_32,
  output logic              write_en4_32,
  output logic              write_en_128,
  output logic [DATA_W-1:0] write_data_1,
  output logic [DATA_W-1:0] write_data_2,
  output logic [DATA_W-1:0] write_data_3,
  output logic [DATA_W-1:0] write_data_4,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              wb_busy,
  output logic              err_timeout,
  output logic              err_spurious
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_LD32  = 2'd1,
    ST_WAIT_LD128 = 2'd2
  } state_t;

  localparam logic [1:0] KIND_LD32  = 2'b01;
  localparam logic [1:0] KIND_LD128 = 2'b10;
  // Last counter value before the drop; the increment that would reach
  // TIMEOUT is the one that fires the error.
  localparam logic [3:0] TMO_LAST   = 4'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q [4];
  logic [ADDR_W-1:0]   addr_d [4];
  logic [DATA_W-1:0]   lane_q [4];
  logic [DATA_W-1:0]   lane_d [4];
  logic [3:0]          en_q, en_d;
  logic                en128_q, en128_d;
  logic [1:0]          beat_q, beat_d;
  logic [3:0]          tmo_q, tmo_d;
  logic                drop_q, drop_d;

  logic [ADDR_W-1:0]   wr_addr_q [4];
  logic [ADDR_W-1:0]   wr_addr_d [4];
  logic [DATA_W-1:0]   wr_data_q [4];
  logic [DATA_W-1:0]   wr_data_d [4];
  logic [3:0]          wr_en_q, wr_en_d;
  logic                wr_en128_q, wr_en128_d;
  logic                err_to_q, err_to_d;
  logic                err_sp_q, err_sp_d;

  logic [ADDR_W-1:0]   in_addr [4];
  logic [DATA_W-1:0]   in_data [4];
  logic                accept;
  logic                is_load;

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign in_addr[gi] = mem.mem_addr[gi*ADDR_W +: ADDR_W];
    assign in_data[gi] = mem.mem_data[gi*DATA_W +: DATA_W];
  end

  assign mem.mem_ready = (state_q == ST_IDLE);
  assign accept        = mem.mem_valid & (state_q == ST_IDLE) & ~flush;
  assign is_load       = (mem.mem_kind == KIND_LD32) || (mem.mem_kind == KIND_LD128);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lane_d     = lane_q;
    en_d       = en_q;
    en128_d    = en128_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    drop_d     = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 4'b0000;
    wr_en128_d = 1'b0;
    err_to_d   = 1'b0;
    err_sp_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A beat right after a flush drop belongs to the abandoned load.
        if (dmem_rvalid && !drop_q) err_sp_d = 1'b1;
        if (accept) begin
          if (is_load) begin
            addr_d  = in_addr;
            lane_d  = in_data;
            en_d    = mem.mem_en;
            en128_d = mem.mem_en_128;
            tmo_d   = 4'd0;
            beat_d  = 2'd0;
            state_d = (mem.mem_kind == KIND_LD32) ? ST_WAIT_LD32 : ST_WAIT_LD128;
          end else begin
            wr_addr_d  = in_addr;
            wr_data_d  = in_data;
            wr_en_d    = mem.mem_en;
            wr_en128_d = mem.mem_en_128;
          end
        end
      end

      ST_WAIT_LD32: begin
        if (flush) begin
          drop_d  = 1'b1;
          tmo_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (dmem_rvalid) begin
          wr_addr_d    = addr_q;
          wr_data_d    = lane_q;
          wr_data_d[0] = dmem_rdata;
          wr_en_d      = en_q;
          wr_en128_d   = en128_q;
          tmo_d        = 4'd0;
          state_d      = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_to_d = 1'b1;
          tmo_d    = 4'd0;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end

      ST_WAIT_LD128: begin
        if (flush) begin
          drop_d  = 1'b1;
          tmo_d   = 4'd0;
          beat_d  = 2'd0;
          state_d = ST_IDLE;
        end else if (dmem_rvalid) begin
          lane_d[beat_q] = dmem_rdata;
          beat_d         = beat_q + 2'd1;
          tmo_d          = 4'd0;
          if (beat_q == 2'd3) begin
            // Final beat goes straight to the output; earlier beats are held.
            wr_addr_d    = addr_q;
            wr_data_d    = lane_q;
            wr_data_d[3] = dmem_rdata;
            wr_en_d      = en_q;
            wr_en128_d   = en128_q;
            state_d      = ST_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_to_d = 1'b1;
          tmo_d    = 4'd0;
          beat_d   = 2'd0;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '{default: '0};
      lane_q     <= '{default: '0};
      en_q       <= 4'b0000;
      en128_q    <= 1'b0;
      beat_q     <= 2'd0;
      tmo_q      <= 4'd0;
      drop_q     <= 1'b0;
      wr_addr_q  <= '{default: '0};
      wr_data_q  <= '{default: '0};
      wr_en_q    <= 4'b0000;
      wr_en128_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_sp_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lane_q     <= lane_d;
      en_q       <= en_d;
      en128_q    <= en128_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      drop_q     <= drop_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      wr_en128_q <= wr_en128_d;
      err_to_q   <= err_to_d;
      err_sp_q   <= err_sp_d;
    end
  end

  assign write_addr1  = wr_addr_q[0];
  assign write_addr2  = wr_addr_q[1];
  assign write_addr3  = wr_addr_q[2];
  assign write_addr4  = wr_addr_q[3];
  assign write_data_1 = wr_data_q[0];
  assign write_data_2 = wr_data_q[1];
  assign write_data_3 = wr_data_q[2];
  assign write_data_4 = wr_data_q[3];
  assign write_en1_32 = wr_en_q[0];
  assign write_en2_32 = wr_en_q[1];
  assign write_en3_32 = wr_en_q[2];
  assign write_en4_32 = wr_en_q[3];
  assign write_en_128 = wr_en128_q;
  assign err_timeout  = err_to_q;
  assign err_spurious = err_sp_q;
  assign wb_busy      = (state_q != ST_IDLE);
  assign wb_rd        = (state_q != ST_IDLE) ? addr_q[0] : '0;

endmodule

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage
// Directed stimulus for wb_stage. Each expected output event (register write,
// timeout pulse, spurious pulse) is queued when its stimulus is issued; a
// monitor on the falling edge pops one entry per observed event.
// ----------------------------------------------------------------------------
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  write_addr1, write_addr2, write_addr3, write_addr4;
  logic        write_en1_32, write_en2_32, write_en3_32, write_en4_32, write_en_128;
  logic [31:0] write_data_1, write_data_2, write_data_3, write_data_4;
  logic [4:0]  wb_rd;
  logic        wb_busy, err_timeout, err_spurious;

  wb_stage_if #(.DATA_W(32), .ADDR_W(5)) mem_if ();

  wb_stage #(.DATA_W(32), .ADDR_W(5), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem(mem_if),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .write_addr1(write_addr1), .write_addr2(write_addr2),
    .write_addr3(write_addr3), .write_addr4(write_addr4),
    .write_en1_32(write_en1_32), .write_en2_32(write_en2_32),
    .write_en3_32(write_en3_32), .write_en4_32(write_en4_32),
    .write_en_128(write_en_128),
    .write_data_1(write_data_1), .write_data_2(write_data_2),
    .write_data_3(write_data_3), .write_data_4(write_data_4),
    .wb_rd(wb_rd), .wb_busy(wb_busy),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         chk_data;
    logic [3:0]   en;
    logic         en128;
    logic         to;
    logic         sp;
    logic [19:0]  a;
    logic [127:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic [3:0] en, input logic en128,
                         input logic [19:0] a, input logic [127:0] d);
    exp_t e;
    e = '{chk_data: 1'b1, en: en, en128: en128, to: 1'b0, sp: 1'b0, a: a, d: d};
    exp_q.push_back(e);
  endtask

  task automatic push_evt(input logic to, input logic sp);
    exp_t e;
    e = '{chk_data: 1'b0, en: 4'b0, en128: 1'b0, to: to, sp: sp, a: '0, d: '0};
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per observed output event.
  always @(negedge clk) begin
    logic [3:0] en_act;
    exp_t       e;
    en_act = {write_en4_32, write_en3_32, write_en2_32, write_en1_32};
    if (|en_act || write_en_128 || err_timeout || err_spurious) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got en=%b en128=%b to=%b sp=%b expected none",
                 en_act, write_en_128, err_timeout, err_spurious);
      end else begin
        e = exp_q.pop_front();
        $display("[%0t] event en=%b en128=%b to=%b sp=%b a1=%0d d1=%h",
                 $time, en_act, write_en_128, err_timeout, err_spurious, write_addr1, write_data_1);
        chk("strobes", {121'b0, en_act, write_en_128, err_timeout, err_spurious},
            {121'b0, e.en, e.en128, e.to, e.sp});
        if (e.chk_data) begin
          chk("write_addr", {108'b0, write_addr4, write_addr3, write_addr2, write_addr1}, {108'b0, e.a});
          chk("write_data", {write_data_4, write_data_3, write_data_2, write_data_1}, e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] kind, input logic [19:0] a, input logic [3:0] en,
                       input logic en128, input logic [127:0] d);
    mem_if.mem_valid  = 1'b1;
    mem_if.mem_kind   = kind;
    mem_if.mem_addr   = a;
    mem_if.mem_en     = en;
    mem_if.mem_en_128 = en128;
    mem_if.mem_data   = d;
  endtask

  task automatic beat(input logic [31:0] v);
    dmem_rvalid = 1'b1;
    dmem_rdata  = v;
    step();
    dmem_rvalid = 1'b0;
  endtask

  task automatic idle_chk(input string name);
    chk({name, "_ready"}, {127'b0, mem_if.mem_ready}, 128'd1);
    chk({name, "_busy"},  {127'b0, wb_busy}, 128'd0);
    chk({name, "_rd"},    {123'b0, wb_rd}, 128'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    mem_if.mem_valid = 1'b0; mem_if.mem_kind = 2'b00; mem_if.mem_addr = '0;
    mem_if.mem_en = 4'b0; mem_if.mem_en_128 = 1'b0; mem_if.mem_data = '0;
    repeat (3) step();

    // Reset values
    idle_chk("reset");
    chk("reset_addr1", {123'b0, write_addr1}, 128'd0);
    chk("reset_data1", {96'b0, write_data_1}, 128'd0);
    chk("reset_errs", {126'b0, err_timeout, err_spurious}, 128'd0);
    rst = 1'b0;
    step();

    // ALU bundles back to back: one commit per cycle, mem_ready stays high
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, {15'd0, 5'(5 + i)}, 4'b0001, 1'b0, {96'd0, 32'h100 + i});
      push_wr(4'b0001, 1'b0, {15'd0, 5'(5 + i)}, {96'd0, 32'h100 + i});
      step();
      chk("alu_ready", {127'b0, mem_if.mem_ready}, 128'd1);
    end
    // Reserved kind behaves as ALU, multiple lanes
    drive(2'b11, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1010, 1'b0, {32'hA4, 32'hA3, 32'hA2, 32'hA1});
    push_wr(4'b1010, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hA4, 32'hA3, 32'hA2, 32'hA1});
    step();
    mem_if.mem_valid = 1'b0;

    // flush in IDLE blocks accept (monitor flags any write)
    flush = 1'b1;
    drive(2'b00, {15'd0, 5'd30}, 4'b0001, 1'b0, {96'd0, 32'hBAD});
    step();
    flush = 1'b0; mem_if.mem_valid = 1'b0;
    step();

    // 32-bit load, beat three cycles later
    drive(2'b01, {5'd12, 5'd11, 5'd10, 5'd9}, 4'b0001, 1'b0, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    push_wr(4'b0001, 1'b0, {5'd12, 5'd11, 5'd10, 5'd9}, {32'hC3, 32'hC2, 32'hC1, 32'hDEAD_BEEF});
    step();
    mem_if.mem_valid = 1'b0;
    chk("ld32_busy", {127'b0, wb_busy}, 128'd1);
    chk("ld32_rd", {123'b0, wb_rd}, 128'd9);
    chk("ld32_ready", {127'b0, mem_if.mem_ready}, 128'd0);
    step(); step();
    beat(32'hDEAD_BEEF);
    idle_chk("ld32_done");

    // 128-bit load with gaps between beats
    drive(2'b10, {5'd0, 5'd0, 5'd0, 5'd2}, 4'b0000, 1'b1, {4{32'hFFFF_FFFF}});
    push_wr(4'b0000, 1'b1, {5'd0, 5'd0, 5'd0, 5'd2}, {32'h44, 32'h33, 32'h22, 32'h11});
    step();
    mem_if.mem_valid = 1'b0;
    beat(32'h11); step(); step();
    beat(32'h22); step();
    chk("ld128_ready", {127'b0, mem_if.mem_ready}, 128'd0);
    beat(32'h33); step(); step(); step();
    chk("ld128_rd", {123'b0, wb_rd}, 128'd2);
    beat(32'h44);
    idle_chk("ld128_done");

    // 128-bit load: two beats then silence -> timeout on 15th idle cycle
    drive(2'b10, {5'd0, 5'd0, 5'd0, 5'd17}, 4'b0000, 1'b1, '0);
    push_evt(1'b1, 1'b0);
    step();
    mem_if.mem_valid = 1'b0;
    beat(32'h1); beat(32'h2);
    repeat (14) step();
    chk("tmo_still_busy", {127'b0, wb_busy}, 128'd1);
    step();
    idle_chk("tmo_dropped");
    step();

    // Beat on the would-be timeout cycle keeps the load alive
    drive(2'b10, {5'd0, 5'd0, 5'd0, 5'd20}, 4'b0000, 1'b1, '0);
    push_wr(4'b0000, 1'b1, {5'd0, 5'd0, 5'd0, 5'd20}, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    step();
    mem_if.mem_valid = 1'b0;
    repeat (14) step();
    beat(32'hD0);
    chk("tmo_saved_busy", {127'b0, wb_busy}, 128'd1);
    beat(32'hD1); beat(32'hD2); beat(32'hD3);
    step();

    // flush with beat in WAIT_LD32: no write; the beat right after is not
    // spurious, a later one is
    drive(2'b01, {15'd0, 5'd9}, 4'b0001, 1'b0, '0);
    step();
    mem_if.mem_valid = 1'b0;
    flush = 1'b1;
    beat(32'h5555);
    flush = 1'b0;
    idle_chk("flush_drop");
    beat(32'h6666);
    step(); step();
    push_evt(1'b0, 1'b1);
    beat(32'h7777);
    step();

    // Reset during a 128-bit load after one beat
    drive(2'b10, {5'd0, 5'd0, 5'd0, 5'd2}, 4'b0000, 1'b1, '0);
    step();
    mem_if.mem_valid = 1'b0;
    beat(32'h11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_chk("rst_mid");
    chk("rst_mid_addr1", {123'b0, write_addr1}, 128'd0);
    chk("rst_mid_data4", {96'b0, write_data_4}, 128'd0);
    drive(2'b00, {15'd0, 5'd3}, 4'b0001, 1'b0, {96'd0, 32'h3333});
    push_wr(4'b0001, 1'b0, {15'd0, 5'd3}, {96'd0, 32'h3333});
    step();
    mem_if.mem_valid = 1'b0;
    repeat (3) step();

    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
